// File: rtl/alu_pkg.sv
// Shared ALU encodings, MIPS opcode/funct constants and the issue slot bundle
// used by the ALU issue stage and its decoder.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_XOR = 3'b010,
        ALU_NOR = 3'b011,
        ALU_ADD = 3'b100,
        ALU_SUB = 3'b101,
        ALU_SLT = 3'b110,
        ALU_SLL = 3'b111
    } alu_op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        A_RS,
        A_SHAMT,
        A_SIXTEEN,
        A_ZERO
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RT,
        B_IMM,
        B_ZERO
    } b_sel_e;

    typedef enum logic {
        EXT_ZERO,
        EXT_SIGN
    } ext_e;

    typedef enum logic [1:0] {
        DST_RD,
        DST_RT,
        DST_NONE
    } dst_sel_e;

    typedef struct packed {
        alu_op_e          op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [4:0]       dest;
        logic             wr_en;
        logic             illegal;
    } slot_t;

    function automatic logic [ALU_W-1:0] ext_imm(input logic [15:0] imm,
                                                  input ext_e ext);
        if (ext == EXT_SIGN) begin
            return {{(ALU_W-16){imm[15]}}, imm};
        end
        return {{(ALU_W-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational MIPS decoder: opcode/funct to ALU op, operand selects,
// immediate extension, destination select and writeback enable.
module alu_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output alu_op_e    op_o,
    output a_sel_e     a_sel_o,
    output b_sel_e     b_sel_o,
    output ext_e       ext_o,
    output dst_sel_e   dst_sel_o,
    output logic       wr_en_o,
    output logic       illegal_o
);

    always_comb begin
        op_o      = ALU_ADD;
        a_sel_o   = A_ZERO;
        b_sel_o   = B_ZERO;
        ext_o     = EXT_ZERO;
        dst_sel_o = DST_NONE;
        wr_en_o   = 1'b0;
        illegal_o = 1'b1;

        unique case (opcode_i)
            OPC_RTYPE: begin
                a_sel_o   = A_RS;
                b_sel_o   = B_RT;
                dst_sel_o = DST_RD;
                wr_en_o   = 1'b1;
                illegal_o = 1'b0;
                unique case (funct_i)
                    FN_AND:          op_o = ALU_AND;
                    FN_OR:           op_o = ALU_OR;
                    FN_XOR:          op_o = ALU_XOR;
                    FN_NOR:          op_o = ALU_NOR;
                    FN_ADD, FN_ADDU: op_o = ALU_ADD;
                    FN_SUB, FN_SUBU: op_o = ALU_SUB;
                    FN_SLT:          op_o = ALU_SLT;
                    FN_SLL: begin
                        op_o    = ALU_SLL;
                        a_sel_o = A_SHAMT;
                    end
                    default: begin
                        op_o      = ALU_ADD;
                        a_sel_o   = A_ZERO;
                        b_sel_o   = B_ZERO;
                        dst_sel_o = DST_NONE;
                        wr_en_o   = 1'b0;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW, OPC_SLTI: begin
                op_o      = (opcode_i == OPC_SLTI) ? ALU_SLT : ALU_ADD;
                a_sel_o   = A_RS;
                b_sel_o   = B_IMM;
                ext_o     = EXT_SIGN;
                dst_sel_o = DST_RT;
                wr_en_o   = (opcode_i != OPC_SW);
                illegal_o = 1'b0;
            end
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                unique case (opcode_i)
                    OPC_ANDI: op_o = ALU_AND;
                    OPC_ORI:  op_o = ALU_OR;
                    default:  op_o = ALU_XOR;
                endcase
                a_sel_o   = A_RS;
                b_sel_o   = B_IMM;
                dst_sel_o = DST_RT;
                wr_en_o   = 1'b1;
                illegal_o = 1'b0;
            end
            OPC_BEQ: begin
                op_o      = ALU_SUB;
                a_sel_o   = A_RS;
                b_sel_o   = B_RT;
                dst_sel_o = DST_RT;
                illegal_o = 1'b0;
            end
            OPC_LUI: begin
                // ALU shifts B left by A, so 16 in A places imm in the top half
                op_o      = ALU_SLL;
                a_sel_o   = A_SIXTEEN;
                b_sel_o   = B_IMM;
                dst_sel_o = DST_RT;
                wr_en_o   = 1'b1;
                illegal_o = 1'b0;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU through a two-entry skid buffer.
// Define ALU_ISSUE_FWD_EN to enable EX/MEM and MEM/WB operand forwarding.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [15:0]      in_imm,
    input  logic [WIDTH-1:0] in_rs_val,
    input  logic [WIDTH-1:0] in_rt_val,
    input  logic             flush,
    input  logic             exm_wr,
    input  logic [4:0]       exm_dest,
    input  logic [WIDTH-1:0] exm_val,
    input  logic             mwb_wr,
    input  logic [4:0]       mwb_dest,
    input  logic [WIDTH-1:0] mwb_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_op,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [4:0]       out_dest,
    output logic             out_wr_en,
    output logic             out_illegal
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_SKID
    } state_e;

    alu_op_e  dec_op;
    a_sel_e   dec_a_sel;
    b_sel_e   dec_b_sel;
    ext_e     dec_ext;
    dst_sel_e dec_dst_sel;
    logic     dec_wr_en;
    logic     dec_illegal;

    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    slot_t            in_slot;

    state_e state_q, state_d;
    slot_t  out_q, out_d;
    slot_t  skid_q, skid_d;
    logic   in_ready_q;
    logic   accept;
    logic   consume;

    alu_decode u_decode (
        .opcode_i  (in_opcode),
        .funct_i   (in_funct),
        .op_o      (dec_op),
        .a_sel_o   (dec_a_sel),
        .b_sel_o   (dec_b_sel),
        .ext_o     (dec_ext),
        .dst_sel_o (dec_dst_sel),
        .wr_en_o   (dec_wr_en),
        .illegal_o (dec_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    // Younger EX/MEM result wins over MEM/WB; r0 is never forwarded
    always_comb begin
        rs_val = in_rs_val;
        if (exm_wr && exm_dest == in_rs && in_rs != 5'd0) begin
            rs_val = exm_val;
        end else if (mwb_wr && mwb_dest == in_rs && in_rs != 5'd0) begin
            rs_val = mwb_val;
        end
    end

    always_comb begin
        rt_val = in_rt_val;
        if (exm_wr && exm_dest == in_rt && in_rt != 5'd0) begin
            rt_val = exm_val;
        end else if (mwb_wr && mwb_dest == in_rt && in_rt != 5'd0) begin
            rt_val = mwb_val;
        end
    end
`else
    logic unused_fwd;

    assign rs_val     = in_rs_val;
    assign rt_val     = in_rt_val;
    assign unused_fwd = ^{exm_wr, exm_dest, exm_val,
                          mwb_wr, mwb_dest, mwb_val};
`endif

    always_comb begin
        in_slot         = '0;
        in_slot.op      = dec_op;
        in_slot.illegal = dec_illegal;

        unique case (dec_a_sel)
            A_RS:      in_slot.a = rs_val;
            A_SHAMT:   in_slot.a = ALU_W'(in_shamt);
            A_SIXTEEN: in_slot.a = ALU_W'(16);
            default:   in_slot.a = '0;
        endcase

        unique case (dec_b_sel)
            B_RT:    in_slot.b = rt_val;
            B_IMM:   in_slot.b = ext_imm(in_imm, dec_ext);
            default: in_slot.b = '0;
        endcase

        unique case (dec_dst_sel)
            DST_RD:  in_slot.dest = in_rd;
            DST_RT:  in_slot.dest = in_rt;
            default: in_slot.dest = 5'd0;
        endcase

        in_slot.wr_en = dec_wr_en && (in_slot.dest != 5'd0);
    end

    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_FULL;
                        out_d   = in_slot;
                    end
                end
                S_FULL: begin
                    if (accept && consume) begin
                        out_d = in_slot;
                    end else if (accept) begin
                        state_d = S_SKID;
                        skid_d  = in_slot;
                    end else if (consume) begin
                        state_d = S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (consume) begin
                        state_d = S_FULL;
                        out_d   = skid_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_SKID);
        end
    end

    assign out_op      = out_q.op;
    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_dest    = out_q.dest;
    assign out_wr_en   = out_q.wr_en;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios plus a randomized run
// against a queue-based model of the two-entry buffer.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic        flush;
    logic        exm_wr;
    logic [4:0]  exm_dest;
    logic [31:0] exm_val;
    logic        mwb_wr;
    logic [4:0]  mwb_dest;
    logic [31:0] mwb_val;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_dest;
    logic        out_wr_en;
    logic        out_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        wr;
        logic        ill;
    } exp_t;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct    (in_funct),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_shamt    (in_shamt),
        .in_imm      (in_imm),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .flush       (flush),
        .exm_wr      (exm_wr),
        .exm_dest    (exm_dest),
        .exm_val     (exm_val),
        .mwb_wr      (mwb_wr),
        .mwb_dest    (mwb_dest),
        .mwb_val     (mwb_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_dest    (out_dest),
        .out_wr_en   (out_wr_en),
        .out_illegal (out_illegal)
    );

    function automatic logic [31:0] fwd(input logic [4:0] r,
                                        input logic [31:0] v);
`ifdef ALU_ISSUE_FWD_EN
        if (r != 5'd0 && exm_wr && exm_dest == r) return exm_val;
        if (r != 5'd0 && mwb_wr && mwb_dest == r) return mwb_val;
`endif
        return v;
    endfunction

    // Instruction semantics straight from the ISA table
    function automatic exp_t model(input logic [5:0] opc,
                                   input logic [5:0] fn,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt,
                                   input logic [4:0] rd,
                                   input logic [4:0] sh,
                                   input logic [15:0] imm,
                                   input logic [31:0] rsv,
                                   input logic [31:0] rtv);
        exp_t        e;
        exp_t        ill;
        logic [31:0] sx;
        logic [31:0] zx;
        sx  = {{16{imm[15]}}, imm};
        zx  = {16'h0000, imm};
        ill = '{op: 3'd4, a: 32'd0, b: 32'd0, dest: 5'd0, wr: 1'b0, ill: 1'b1};
        e   = '{op: 3'd4, a: rsv, b: sx, dest: rt, wr: 1'b1, ill: 1'b0};
        case (opc)
            6'h00: begin
                e.b    = rtv;
                e.dest = rd;
                case (fn)
                    6'h24:        e.op = 3'd0;
                    6'h25:        e.op = 3'd1;
                    6'h26:        e.op = 3'd2;
                    6'h27:        e.op = 3'd3;
                    6'h20, 6'h21: e.op = 3'd4;
                    6'h22, 6'h23: e.op = 3'd5;
                    6'h2A:        e.op = 3'd6;
                    6'h00: begin
                        e.op = 3'd7;
                        e.a  = {27'd0, sh};
                    end
                    default: e = ill;
                endcase
            end
            6'h08, 6'h09, 6'h23: e.op = 3'd4;
            6'h0A:               e.op = 3'd6;
            6'h0C: begin e.op = 3'd0; e.b = zx; end
            6'h0D: begin e.op = 3'd1; e.b = zx; end
            6'h0E: begin e.op = 3'd2; e.b = zx; end
            6'h2B: e.wr = 1'b0;
            6'h04: begin e.op = 3'd5; e.b = rtv; e.wr = 1'b0; end
            6'h0F: begin e.op = 3'd7; e.a = 32'd16; e.b = zx; end
            default: e = ill;
        endcase
        if (e.dest == 5'd0) e.wr = 1'b0;
        return e;
    endfunction

    function automatic exp_t got_slot();
        return {out_op, out_a, out_b, out_dest, out_wr_en, out_illegal};
    endfunction

    task automatic set_in(input logic v, input logic [5:0] opc,
                          input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] sh, input logic [15:0] imm,
                          input logic [31:0] rsv, input logic [31:0] rtv);
        in_valid  = v;
        in_opcode = opc;
        in_funct  = fn;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_imm    = imm;
        in_rs_val = rsv;
        in_rt_val = rtv;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (got_slot() !== exp_t'(0)) begin
            n_bad++;
            $display("FAIL reset_slot got %h want 0", got_slot());
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        set_in(1'b1, 6'h08, 6'h15, 5'd3, 5'd7, 5'd9, 5'd2, 16'hFFFF,
               32'd5, 32'd123);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL addi_valid got %b want 1", out_valid);
        end
        n_cmp++;
        if ({out_op, out_a, out_b, out_dest, out_wr_en} !==
            {3'd4, 32'd5, 32'hFFFF_FFFF, 5'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL addi_slot got op=%b a=%h b=%h d=%0d w=%b want op=100 a=5 b=ffffffff d=7 w=1",
                     out_op, out_a, out_b, out_dest, out_wr_en);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL addi_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_lui();
        logic [31:0] res;
        out_ready = 1'b1;
        set_in(1'b1, 6'h0F, 6'h00, 5'd2, 5'd8, 5'd0, 5'd0, 16'h1234,
               32'hDEAD_BEEF, 32'd0);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_op, out_a, out_b, out_dest, out_wr_en, out_illegal} !==
            {3'd7, 32'd16, 32'h0000_1234, 5'd8, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL lui_slot got op=%b a=%h b=%h d=%0d want op=111 a=10 b=1234 d=8",
                     out_op, out_a, out_b, out_dest);
        end
        res = out_b << out_a[4:0];
        n_cmp++;
        if (res !== 32'h1234_0000) begin
            n_bad++;
            $display("FAIL lui_result got %h want 12340000", res);
        end
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        set_in(1'b1, 6'h00, 6'h3F, 5'd5, 5'd6, 5'd7, 5'd3, 16'h0042,
               $urandom, $urandom);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_illegal, out_wr_en, out_op, out_a, out_b} !==
            {1'b1, 1'b0, 3'd4, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL illegal_slot got ill=%b w=%b op=%b a=%h b=%h want ill=1 w=0 op=100 a=0 b=0",
                     out_illegal, out_wr_en, out_op, out_a, out_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e1;
        exp_t e2;
        out_ready = 1'b0;
        e1 = model(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 32'd11, 32'd22);
        e2 = model(6'h00, 6'h22, 5'd1, 5'd2, 5'd4, 5'd0, 16'd0, 32'd33, 32'd44);
        set_in(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 32'd11, 32'd22);
        tick();
        set_in(1'b1, 6'h00, 6'h22, 5'd1, 5'd2, 5'd4, 5'd0, 16'd0, 32'd33, 32'd44);
        n_cmp++;
        if (got_slot() !== e1 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_first got %h rdy=%b want %h rdy=1", got_slot(), in_ready, e1);
        end
        tick();
        set_in(1'b1, 6'h00, 6'h25, 5'd1, 5'd2, 5'd5, 5'd0, 16'd0, 32'd55, 32'd66);
        n_cmp++;
        if (got_slot() !== e1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_skid got %h rdy=%b want %h rdy=0", got_slot(), in_ready, e1);
        end
        tick();
        n_cmp++;
        if (got_slot() !== e1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold got %h rdy=%b v=%b want %h rdy=0 v=1",
                     got_slot(), in_ready, out_valid, e1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (got_slot() !== e2 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_drain2 got %h v=%b rdy=%b want %h v=1 rdy=1",
                     got_slot(), out_valid, in_ready, e2);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_empty got %b want 0", out_valid);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] ea;
        logic [31:0] eb;
        out_ready = 1'b1;
        exm_wr = 1'b1; exm_dest = 5'd4; exm_val = 32'hA;
        mwb_wr = 1'b1; mwb_dest = 5'd4; mwb_val = 32'hB;
        set_in(1'b1, 6'h00, 6'h20, 5'd4, 5'd4, 5'd6, 5'd0, 16'd0, 32'd1, 32'd2);
        tick();
`ifdef ALU_ISSUE_FWD_EN
        ea = 32'hA; eb = 32'hA;
`else
        ea = 32'd1; eb = 32'd2;
`endif
        n_cmp++;
        if (out_a !== ea || out_b !== eb) begin
            n_bad++;
            $display("FAIL fwd_exm got a=%h b=%h want a=%h b=%h", out_a, out_b, ea, eb);
        end
        exm_dest = 5'd0;
        tick();
`ifdef ALU_ISSUE_FWD_EN
        ea = 32'hB; eb = 32'hB;
`else
        ea = 32'd1; eb = 32'd2;
`endif
        n_cmp++;
        if (out_a !== ea || out_b !== eb) begin
            n_bad++;
            $display("FAIL fwd_mwb got a=%h b=%h want a=%h b=%h", out_a, out_b, ea, eb);
        end
        mwb_dest = 5'd0;
        set_in(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd6, 5'd0, 16'd0, 32'd7, 32'd8);
        tick();
        n_cmp++;
        if (out_a !== 32'd7 || out_b !== 32'd8) begin
            n_bad++;
            $display("FAIL fwd_r0 got a=%h b=%h want a=7 b=8", out_a, out_b);
        end
        in_valid = 1'b0;
        exm_wr   = 1'b0;
        mwb_wr   = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(1'b1, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'd1, 32'd1, 32'd0);
        tick();
        tick();
        set_in(1'b1, 6'h08, 6'h00, 5'd1, 5'd3, 5'd0, 5'd0, 16'd2, 32'd1, 32'd0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_skid got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        set_in(1'b1, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'd1, 32'd1, 32'd0);
        tick();
        set_in(1'b1, 6'h08, 6'h00, 5'd1, 5'd3, 5'd0, 5'd0, 16'd2, 32'd1, 32'd0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_full got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        set_in(1'b1, 6'h0D, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF, 32'h55, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got_slot() !== exp_t'(0)) begin
            n_bad++;
            $display("FAIL reset_mid got v=%b rdy=%b slot=%h want v=0 rdy=1 slot=0",
                     out_valid, in_ready, got_slot());
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_after got %b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          sz;
        logic [5:0]  opcs [12];
        logic [5:0]  fns  [11];
        opcs = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04};
        fns  = '{6'h00, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                 6'h26, 6'h27, 6'h2A, 6'h3F};
        for (int i = 0; i < 400; i++) begin
            n_cmp++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                n_bad++;
                $display("FAIL rand_ctrl cyc %0d got v=%b rdy=%b want occupancy %0d",
                         i, out_valid, in_ready, q.size());
            end
            if (q.size() != 0) begin
                n_cmp++;
                if (got_slot() !== q[0]) begin
                    n_bad++;
                    $display("FAIL rand_slot cyc %0d got %h want %h", i, got_slot(), q[0]);
                end
            end
            set_in($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 7) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 11)],
                   ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 10)],
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom),
                   $urandom, $urandom);
            exm_wr    = $urandom_range(0, 1) != 0;
            exm_dest  = 5'($urandom_range(0, 7));
            exm_val   = $urandom;
            mwb_wr    = $urandom_range(0, 1) != 0;
            mwb_dest  = 5'($urandom_range(0, 7));
            mwb_val   = $urandom;
            flush     = $urandom_range(0, 19) == 0;
            out_ready = $urandom_range(0, 2) != 0;
            e  = model(in_opcode, in_funct, in_rs, in_rt, in_rd, in_shamt, in_imm,
                       fwd(in_rs, in_rs_val), fwd(in_rt, in_rt_val));
            sz = q.size();
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (out_ready && sz > 0) void'(q.pop_front());
                if (in_valid && sz < 2) q.push_back(e);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        exm_wr    = 1'b0;
        mwb_wr    = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_final got %b want 0", out_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        exm_wr    = 1'b0;
        exm_dest  = 5'd0;
        exm_val   = 32'd0;
        mwb_wr    = 1'b0;
        mwb_dest  = 5'd0;
        mwb_val   = 32'd0;
        set_in(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 32'd0, 32'd0);
        @(negedge clk);
        test_reset();
        test_addi();
        test_lui();
        test_illegal();
        test_back_to_back();
        test_forwarding();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
